// File: rtl/jump_control_unit_pkg.sv
// jump_ctrl_pkg: shared state encoding, branch-mode constants and flush-counter width
package jump_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REDIRECT = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic BR_EQ = 1'b0;
  localparam logic BR_NE = 1'b1;
  localparam int FLUSH_CNT_W = 4;
endpackage

// File: rtl/jump_control_unit_if.sv
// jump_control_unit_if: request and redirect signals between decode/execute and the PC/IF-ID stage
interface jump_control_unit_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W = 8
);
  logic jump;
  logic branch;
  logic branch_ne;
  logic zero;
  logic [ADDR_W-1:0] target;
  logic stall_in;
  logic pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic flush;
  logic busy;
  logic [CNT_W-1:0] taken_count;
  modport master (
    output jump, branch, branch_ne, zero, target, stall_in,
    input pc_load, pc_target, flush, busy, taken_count
  );
  modport slave (
    input jump, branch, branch_ne, zero, target, stall_in,
    output pc_load, pc_target, flush, busy, taken_count
  );
endinterface

// File: rtl/jump_control_unit_flush_counter.sv
// jump_flush_counter: loadable down-counter that stops at zero and flags it
module jump_flush_counter #(
  parameter int W = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  input  logic [W-1:0] din,
  output logic zero
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins over decrement; decrement stops at zero
  always_comb cnt_d = load ? din : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/jump_control_unit.sv
// jump_control_unit: resolves jumps/branches into a one-cycle PC redirect followed by a timed flush
module jump_control_unit
  import jump_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clock,
  input logic reset,
  jump_control_unit_if.slave bus
);
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("FLUSH_CYCLES must be within 1..15");
  end
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic pc_load_q, pc_load_d, flush_q, flush_d, busy_q, busy_d;
  logic take, cnt_load, cnt_en, cnt_zero;
  assign take = bus.jump | (bus.branch & (bus.zero ^ bus.branch_ne));
  jump_flush_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
    .clock(clock),
    .reset(reset),
    .load(cnt_load),
    .en(cnt_en),
    .din(FLUSH_LOAD),
    .zero(cnt_zero)
  );
  // next state; a stall freezes everything, and outputs follow the next state so they stay registered
  always_comb begin
    state_d = state_q;
    pc_target_d = pc_target_q;
    taken_count_d = taken_count_q;
    cnt_load = 1'b0;
    cnt_en = 1'b0;
    if (!bus.stall_in) begin
      case (state_q)
        IDLE: if (take) begin
          state_d = REDIRECT;
          pc_target_d = bus.target;
          taken_count_d = &taken_count_q ? taken_count_q : taken_count_q + CNT_W'(1);
        end
        REDIRECT: begin
          state_d = FLUSH_CYCLES == 1 ? IDLE : FLUSH;
          cnt_load = FLUSH_CYCLES > 1;
        end
        FLUSH: begin
          cnt_en = 1'b1;
          state_d = cnt_zero ? IDLE : FLUSH;
        end
        default: state_d = IDLE;
      endcase
    end
    pc_load_d = state_d == REDIRECT;
    flush_d = state_d != IDLE;
    busy_d = state_d != IDLE;
  end
  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_target_q <= RESET_PC;
      taken_count_q <= '0;
      pc_load_q <= 1'b0;
      flush_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_target_q <= pc_target_d;
      taken_count_q <= taken_count_d;
      pc_load_q <= pc_load_d;
      flush_q <= flush_d;
      busy_q <= busy_d;
    end
  end
  assign bus.pc_load = pc_load_q;
  assign bus.pc_target = pc_target_q;
  assign bus.flush = flush_q;
  assign bus.busy = busy_q;
  assign bus.taken_count = taken_count_q;
endmodule

// File: tb/tb_jump_control_unit.sv
// tb_jump_control_unit: directed scoreboard bench for the default build and a FLUSH_CYCLES=1/CNT_W=2 build
module tb_jump_control_unit;
  import jump_ctrl_pkg::*;
  typedef struct {
    logic pc_load;
    logic flush;
    logic busy;
    logic [7:0] pc_target;
    logic [7:0] taken_count;
  } exp_t;
  logic clock = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  jump_control_unit_if #(.ADDR_W(8), .CNT_W(8)) ia ();
  jump_control_unit_if #(.ADDR_W(8), .CNT_W(2)) ib ();
  jump_control_unit #(.ADDR_W(8), .FLUSH_CYCLES(2), .CNT_W(8), .RESET_PC(8'h00)) dut_a (
    .clock(clock), .reset(rst_a), .bus(ia)
  );
  jump_control_unit #(.ADDR_W(8), .FLUSH_CYCLES(1), .CNT_W(2), .RESET_PC(8'hA5)) dut_b (
    .clock(clock), .reset(rst_b), .bus(ib)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input string field, input logic [7:0] got, input logic [7:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s.%s got %0h want %0h", tag, field, got, want);
    end
  endtask
  task automatic step(input string tag, input bit sel, input logic r, input logic j, input logic b,
                      input logic ne, input logic z, input logic [7:0] t, input logic s,
                      input logic el, input logic ef, input logic eb, input logic [7:0] ept,
                      input logic [7:0] ec);
    exp_t e;
    exp_t o;
    if (!sel) begin
      rst_a = r; ia.jump = j; ia.branch = b; ia.branch_ne = ne; ia.zero = z; ia.target = t; ia.stall_in = s;
    end else begin
      rst_b = r; ib.jump = j; ib.branch = b; ib.branch_ne = ne; ib.zero = z; ib.target = t; ib.stall_in = s;
    end
    sb.push_back('{el, ef, eb, ept, ec});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    o = sel ? exp_t'{ib.pc_load, ib.flush, ib.busy, ib.pc_target, {6'd0, ib.taken_count}}
            : exp_t'{ia.pc_load, ia.flush, ia.busy, ia.pc_target, ia.taken_count};
    chk(tag, "pc_load", {7'd0, o.pc_load}, {7'd0, e.pc_load});
    chk(tag, "flush", {7'd0, o.flush}, {7'd0, e.flush});
    chk(tag, "busy", {7'd0, o.busy}, {7'd0, e.busy});
    chk(tag, "pc_target", o.pc_target, e.pc_target);
    chk(tag, "taken_count", o.taken_count, e.taken_count);
  endtask
  initial begin
    ia.jump = 0; ia.branch = 0; ia.branch_ne = 0; ia.zero = 0; ia.target = 0; ia.stall_in = 0;
    ib.jump = 0; ib.branch = 0; ib.branch_ne = 0; ib.zero = 0; ib.target = 0; ib.stall_in = 0;
    step("a_reset", 0, 1, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    step("a_jump", 0, 0, 1, 0, BR_EQ, 0, 8'h3C, 0, 1, 1, 1, 8'h3C, 1);
    step("a_jump_fl", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 1, 1, 8'h3C, 1);
    step("a_jump_idle", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 0, 0, 8'h3C, 1);
    step("beq_nt", 0, 0, 0, 1, BR_EQ, 0, 8'h10, 0, 0, 0, 0, 8'h3C, 1);
    step("beq_t", 0, 0, 0, 1, BR_EQ, 1, 8'h10, 0, 1, 1, 1, 8'h10, 2);
    step("beq_fl", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 1, 1, 8'h10, 2);
    step("beq_idle", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 0, 0, 8'h10, 2);
    step("bne_nt", 0, 0, 0, 1, BR_NE, 1, 8'h55, 0, 0, 0, 0, 8'h10, 2);
    step("bne_t", 0, 0, 0, 1, BR_NE, 0, 8'h55, 0, 1, 1, 1, 8'h55, 3);
    step("bne_fl", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 1, 1, 8'h55, 3);
    step("bne_idle", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 0, 0, 8'h55, 3);
    step("hold_acc1", 0, 0, 1, 0, BR_EQ, 0, 8'h20, 0, 1, 1, 1, 8'h20, 4);
    step("hold_ign_rd", 0, 0, 1, 0, BR_EQ, 0, 8'h77, 0, 0, 1, 1, 8'h20, 4);
    step("hold_ign_fl", 0, 0, 1, 1, BR_EQ, 1, 8'h77, 0, 0, 0, 0, 8'h20, 4);
    step("hold_acc2", 0, 0, 1, 0, BR_EQ, 0, 8'h20, 0, 1, 1, 1, 8'h20, 5);
    step("hold_ign_rd2", 0, 0, 1, 0, BR_EQ, 0, 8'h20, 0, 0, 1, 1, 8'h20, 5);
    step("hold_ign_fl2", 0, 0, 1, 0, BR_EQ, 0, 8'h20, 0, 0, 0, 0, 8'h20, 5);
    step("hold_off", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 0, 0, 8'h20, 5);
    for (int i = 0; i < 3; i++)
      step("stall_idle", 0, 0, 1, 0, BR_EQ, 0, 8'h44, 1, 0, 0, 0, 8'h20, 5);
    step("stall_release", 0, 0, 1, 0, BR_EQ, 0, 8'h44, 0, 1, 1, 1, 8'h44, 6);
    for (int i = 0; i < 2; i++)
      step("stall_redirect", 0, 0, 1, 0, BR_EQ, 0, 8'h99, 1, 1, 1, 1, 8'h44, 6);
    step("stall_to_fl", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 1, 1, 8'h44, 6);
    step("stall_to_idle", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 0, 0, 8'h44, 6);
    step("rst_jump", 0, 0, 1, 0, BR_EQ, 0, 8'h66, 0, 1, 1, 1, 8'h66, 7);
    step("rst_in_fl", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 1, 1, 8'h66, 7);
    step("rst_mid", 0, 1, 1, 0, BR_EQ, 0, 8'h88, 1, 0, 0, 0, 8'h00, 0);
    step("rst_after", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    step("post_rst_jump", 0, 0, 1, 0, BR_EQ, 0, 8'h99, 0, 1, 1, 1, 8'h99, 1);
    step("a_park", 0, 0, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 1, 1, 8'h99, 1);
    step("b_reset", 1, 1, 0, 0, BR_EQ, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] cnt;
      cnt = (i / 2 + 1 > 3) ? 8'd3 : 8'(i / 2 + 1);
      if (i % 2 == 0)
        step("b_accept", 1, 0, 1, 0, BR_EQ, 0, 8'(8'h80 + i), 0, 1, 1, 1, 8'(8'h80 + i), cnt);
      else
        step("b_idle", 1, 0, 1, 0, BR_EQ, 0, 8'(8'h80 + i), 0, 0, 0, 0, 8'(8'h80 + i - 1), cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
